// File: rtl/data_cache_wb.sv
// data_cache_wb: direct-mapped write-back/write-allocate data cache with line-wide memory refill/writeback
module data_cache_wb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_WORDS = 8,
  parameter int SETS = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ADDR_W-1:0]            address_i,
  input  logic [DATA_W-1:0]            write_data_i,
  input  logic                         MemRead_i,
  input  logic                         MemWrite_i,
  output logic [DATA_W-1:0]            read_data_o,
  output logic                         stall_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [LINE_WORDS*DATA_W-1:0] mem_wdata_o,
  input  logic                         mem_ack_i,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_rdata_i,
  output logic [31:0]                  hit_cnt_o,
  output logic [31:0]                  miss_cnt_o
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
  state_t state, state_d;
  logic [SETS-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [SETS];
  logic [LINE_WORDS-1:0][DATA_W-1:0] data [SETS];
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [TAG_W-1:0] tag;
  logic [DATA_W-1:0] word, rd_q;
  logic idle, req, hit, hit_evt, miss, fill, vd, unused_bits;
  assign unused_bits = ^address_i[1:0];
  assign idx = address_i[OFF_W+2 +: IDX_W];
  assign off = address_i[2 +: OFF_W];
  assign tag = address_i[ADDR_W-1 -: TAG_W];
  assign idle = state == IDLE;
  assign req = MemRead_i | MemWrite_i;
  assign hit = valid[idx] && tags[idx] == tag;
  assign word = data[idx][off];
  assign hit_evt = idle && req && hit;
  assign miss = idle && req && !hit;
  assign fill = state == ALLOCATE && mem_ack_i;
  assign vd = valid[idx] && dirty[idx];
  assign stall_o = !idle || miss;
  // Loads/stores on a hit return the pre-store word; otherwise the last value is held.
  assign read_data_o = hit_evt ? word : rd_q;
  always_ff @(posedge clk_i)
    if (!rst_i) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    state_d = miss ? (vd ? WRITEBACK : ALLOCATE) :
              (idle || !mem_ack_i) ? state :
              state == WRITEBACK ? ALLOCATE : IDLE;
  end
  always_ff @(posedge clk_i)
    if (!rst_i) begin
      valid <= '0;
      dirty <= '0;
      hit_cnt_o <= '0;
      miss_cnt_o <= '0;
      rd_q <= '0;
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      if (hit_evt) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
        rd_q <= word;
      end
      if (hit_evt && MemWrite_i) dirty[idx] <= 1'b1;
      if (miss) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
        mem_req_o <= 1'b1;
        mem_we_o <= vd;
        mem_addr_o <= {vd ? tags[idx] : tag, idx, {(OFF_W+2){1'b0}}};
        if (vd) mem_wdata_o <= data[idx];
      end
      // Writeback done: the refill request follows with no idle cycle between.
      if (state == WRITEBACK && mem_ack_i) begin
        mem_we_o <= 1'b0;
        mem_addr_o <= {tag, idx, {(OFF_W+2){1'b0}}};
      end
      if (fill) begin
        mem_req_o <= 1'b0;
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  always_ff @(posedge clk_i)
    if (fill) begin
      tags[idx] <= tag;
      data[idx] <= mem_rdata_i;
    end else if (hit_evt && MemWrite_i) data[idx][off] <= write_data_i;
endmodule

// File: tb/tb_data_cache_wb.sv
// tb_data_cache_wb: directed table, hand sequences and random accesses against a set/tag + flat-memory model
module tb_data_cache_wb;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic mrd = 1'b0, mwr = 1'b0;
  logic [31:0] read_data, mem_addr, hit_cnt, miss_cnt;
  logic stall, mem_req, mem_we;
  logic [255:0] mem_wdata, mem_rdata = '0;
  logic mem_ack = 1'b0;
  always #5 clk = ~clk;
  data_cache_wb dut (
    .clk_i(clk), .rst_i(rst_n), .address_i(address), .write_data_i(wdata),
    .MemRead_i(mrd), .MemWrite_i(mwr), .read_data_o(read_data), .stall_o(stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  logic [31:0] bmem [int];
  logic [31:0] refm [int];
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h5A5A_1234;
  endfunction
  function automatic logic [31:0] bget(input logic [31:0] a);
    return bmem.exists(int'(a >> 2)) ? bmem[int'(a >> 2)] : init_word(a & ~32'h3);
  endfunction
  function automatic logic [31:0] rget(input logic [31:0] a);
    return refm.exists(int'(a >> 2)) ? refm[int'(a >> 2)] : init_word(a & ~32'h3);
  endfunction
  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = bget(a + 32'(4 * w));
    return l;
  endfunction
  function automatic void mem_write(input logic [31:0] a, input logic [255:0] l);
    for (int w = 0; w < 8; w++) bmem[int'(a >> 2) + w] = l[w*32 +: 32];
  endfunction
  int ack_delay = 0, wait_cnt = 0, wb_cnt = 0, hold_viol = 0;
  logic [31:0] wb_addr = '0, rd_addr = '0, p_addr = '0;
  logic [255:0] wb_line = '0, p_wdata = '0;
  logic hold_ok = 1'b0, p_we = 1'b0;
  // Memory responder plus a monitor that the request stays frozen until acked.
  always @(posedge clk) begin
    if (rst_n && hold_ok && mem_req && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
      hold_viol <= hold_viol + 1;
    hold_ok <= rst_n && mem_req && !mem_ack;
    p_addr <= mem_addr;
    p_we <= mem_we;
    p_wdata <= mem_wdata;
    mem_ack <= 1'b0;
    if (!rst_n || !mem_req || mem_ack) wait_cnt <= 0;
    else if (wait_cnt < ack_delay) wait_cnt <= wait_cnt + 1;
    else begin
      mem_ack <= 1'b1;
      wait_cnt <= 0;
      if (mem_we) begin
        wb_cnt <= wb_cnt + 1;
        wb_addr <= mem_addr;
        wb_line <= mem_wdata;
        mem_write(mem_addr, mem_wdata);
      end else begin
        rd_addr <= mem_addr;
        mem_rdata <= mem_line(mem_addr);
      end
    end
  end
  bit rv [32];
  bit rdt [32];
  logic [21:0] rt [32];
  int e_hit = 0, e_miss = 0, e_wb = 0;
  function automatic void ref_reset();
    for (int i = 0; i < 32; i++) begin
      rv[i] = 1'b0;
      rdt[i] = 1'b0;
    end
    e_hit = 0;
    e_miss = 0;
    refm.delete();
    foreach (bmem[k]) refm[k] = bmem[k];
  endfunction
  function automatic void model(input logic [31:0] a, d, input bit wr, input int dly,
                                output logic [31:0] e_rd, output int e_st);
    int s = int'(a[9:5]);
    bit h = rv[s] && rt[s] == a[31:10];
    e_st = h ? 0 : (rv[s] && rdt[s]) ? 5 + 2 * dly : 3 + dly;
    if (!h) begin
      e_miss++;
      if (rv[s] && rdt[s]) e_wb++;
      rv[s] = 1'b1;
      rt[s] = a[31:10];
      rdt[s] = 1'b0;
    end
    e_hit++;
    e_rd = rget(a);
    if (wr) begin
      refm[int'(a >> 2)] = d;
      rdt[s] = 1'b1;
    end
  endfunction
  task automatic access(input logic [31:0] a, d, input bit rd, wr, output logic [31:0] got, output int st);
    @(negedge clk);
    address = a;
    wdata = d;
    mrd = rd;
    mwr = wr;
    #1;
    st = 0;
    while (stall && st < 400) begin
      @(negedge clk);
      #1;
      st++;
    end
    got = read_data;
    @(posedge clk);
    #1;
    mrd = 1'b0;
    mwr = 1'b0;
  endtask
  typedef struct {
    logic [31:0] a, d;
    bit rd, wr;
    logic [31:0] e_rd;
    int e_st, e_hit, e_miss;
  } vec_t;
  vec_t tbl [9];
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [31:0] got, er;
    int st, es;
    tbl[0] = '{32'h040, 32'h0, 1, 0, 32'hDEAD_BEEF, 3, 1, 1};
    tbl[1] = '{32'h044, 32'h1234_5678, 0, 1, init_word(32'h044), 0, 2, 1};
    tbl[2] = '{32'h044, 32'h0, 1, 0, 32'h1234_5678, 0, 3, 1};
    tbl[3] = '{32'h000, 32'hCAFE_F00D, 0, 1, init_word(32'h000), 3, 4, 2};
    tbl[4] = '{32'h7E0, 32'h0, 1, 0, init_word(32'h7E0), 3, 5, 3};
    tbl[5] = '{32'hFE4, 32'h0, 1, 0, init_word(32'hFE4), 3, 6, 4};
    tbl[6] = '{32'h000, 32'h0, 1, 0, 32'hCAFE_F00D, 0, 7, 4};
    tbl[7] = '{32'hFE4, 32'h0BAD_F00D, 1, 1, init_word(32'hFE4), 0, 8, 4};
    tbl[8] = '{32'hFE4, 32'h0, 1, 0, 32'h0BAD_F00D, 0, 9, 4};
    bmem[16] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read_data", read_data, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    rst_n = 1'b1;
    ref_reset();
    for (int i = 0; i < 9; i++) begin
      model(tbl[i].a, tbl[i].d, tbl[i].wr, 0, er, es);
      access(tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].wr, got, st);
      chk($sformatf("tbl%0d_rdata", i), got, tbl[i].e_rd);
      chk($sformatf("tbl%0d_stall_cycles", i), st, tbl[i].e_st);
      chk($sformatf("tbl%0d_hit_cnt", i), hit_cnt, tbl[i].e_hit);
      chk($sformatf("tbl%0d_miss_cnt", i), miss_cnt, tbl[i].e_miss);
    end
    chk("tbl_no_writeback", wb_cnt, 0);
    model(32'h440, 0, 0, 0, er, es);
    access(32'h440, 0, 1, 0, got, st);
    chk("wb_addr", wb_addr, 32'h40);
    chk("wb_word0", wb_line[31:0], 32'hDEAD_BEEF);
    chk("wb_word1", wb_line[63:32], 32'h1234_5678);
    chk("wb_alloc_addr", rd_addr, 32'h440);
    chk("wb_stall_cycles", st, 5);
    chk("wb_rdata", got, init_word(32'h440));
    chk("wb_count", wb_cnt, 1);
    chk("wb_miss_cnt", miss_cnt, 5);
    model(32'h080, 32'h600D_CAFE, 1, 0, er, es);
    access(32'h080, 32'h600D_CAFE, 0, 1, got, st);
    ack_delay = 10;
    model(32'h880, 0, 0, 10, er, es);
    access(32'h880, 0, 1, 0, got, st);
    chk("slow_stall_cycles", st, 25);
    chk("slow_rdata", got, init_word(32'h880));
    chk("slow_wb_addr", wb_addr, 32'h80);
    chk("slow_wb_word0", wb_line[31:0], 32'h600D_CAFE);
    chk("slow_hold_violations", hold_viol, 0);
    ack_delay = 50;
    @(negedge clk);
    address = 32'h100;
    mrd = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_in_alloc_req", {stall, mem_req, mem_we}, 3'b110);
    rst_n = 1'b0;
    mrd = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_hit_cnt", hit_cnt, 0);
    chk("abort_miss_cnt", miss_cnt, 0);
    chk("abort_stall", stall, 0);
    chk("abort_read_data", read_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    ref_reset();
    model(32'h040, 0, 0, 0, er, es);
    access(32'h040, 0, 1, 0, got, st);
    chk("reload_stall_cycles", st, 3);
    chk("reload_rdata", got, 32'hDEAD_BEEF);
    chk("reload_miss_cnt", miss_cnt, 1);
    chk("reload_hit_cnt", hit_cnt, 1);
    for (int i = 0; i < 300; i++) begin
      int sets [5] = '{0, 1, 2, 30, 31};
      logic [31:0] a, d;
      int op = $urandom_range(0, 2);
      a = (32'($urandom_range(0, 3)) << 10) | (32'(sets[$urandom_range(0, 4)]) << 5) | (32'($urandom_range(0, 7)) << 2);
      d = $urandom;
      ack_delay = $urandom_range(0, 3);
      model(a, d, op != 0, ack_delay, er, es);
      access(a, d, op != 1, op != 0, got, st);
      chk($sformatf("rnd%0d_rdata@%0h", i, a), got, er);
      chk($sformatf("rnd%0d_stall_cycles", i), st, es);
      chk($sformatf("rnd%0d_hit_cnt", i), hit_cnt, e_hit);
      chk($sformatf("rnd%0d_miss_cnt", i), miss_cnt, e_miss);
    end
    chk("final_wb_count", wb_cnt, e_wb);
    chk("final_hold_violations", hold_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
